// File: rtl/a_rom_matmul_seq.sv
// Address/strobe sequencer for the 3x3 A-coefficient ROM in a C = A*B product.
// Streams one B column per handshake and aligns MAC strobes with the ROM's registered read.
module a_rom_matmul_seq #(
    parameter int                N_ROW     = 3,
    parameter int                N_COL     = 3,
    parameter int                NUM_VEC   = 3,
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [1:0]        row_idx,
    output logic [1:0]        col_idx,
    output logic [1:0]        vec_idx,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        RUN,
        DRAIN,
        EMIT
    } state_t;

    localparam logic [1:0]        ROW_LAST = 2'(N_ROW - 1);
    localparam logic [1:0]        COL_LAST = 2'(N_COL - 1);
    localparam logic [1:0]        VEC_LAST = 2'(NUM_VEC - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(N_ROW);

    state_t     state, state_next;
    logic [1:0] row, row_next;
    logic [1:0] col, col_next;
    logic [1:0] vec, vec_next;

    // Alignment stage: RUN-cycle issue/row/col delayed by the ROM read latency.
    logic       issue_q;
    logic [1:0] row_q;
    logic [1:0] col_q;

    logic [ADDR_W-1:0] run_addr;
    assign run_addr = ADDR_W'(col) * ROW_STEP + ADDR_W'(row);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        vec_next   = vec;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_B;
                    vec_next   = '0;
                end
            end
            WAIT_B: begin
                if (b_valid) begin
                    state_next = RUN;
                    row_next   = '0;
                    col_next   = '0;
                end
            end
            RUN: begin
                if (row == ROW_LAST) begin
                    row_next = '0;
                    col_next = col + 2'd1;
                    if (col == COL_LAST) begin
                        state_next = DRAIN;
                        col_next   = '0;
                    end
                end else begin
                    row_next = row + 2'd1;
                end
            end
            DRAIN: state_next = EMIT;
            EMIT: begin
                if (vec == VEC_LAST) begin
                    state_next = IDLE;
                    vec_next   = '0;
                end else begin
                    state_next = WAIT_B;
                    vec_next   = vec + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            vec     <= '0;
            issue_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state   <= state_next;
            row     <= row_next;
            col     <= col_next;
            vec     <= vec_next;
            issue_q <= (state == RUN);
            row_q   <= (state == RUN) ? row : 2'd0;
            col_q   <= (state == RUN) ? col : 2'd0;
        end
    end

    // Outside RUN the idle address makes the ROM return 0, so unqualified data is harmless.
    assign rom_addr  = (state == RUN) ? run_addr : IDLE_ADDR;
    assign b_ready   = (state == WAIT_B);
    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign done      = (state == EMIT) && (vec == VEC_LAST);
    assign mac_en    = issue_q;
    assign mac_clr   = issue_q && (col_q == 2'd0);
    assign row_idx   = row_q;
    assign col_idx   = col_q;
    assign vec_idx   = vec;

endmodule

// File: tb/tb_a_rom_matmul_seq.sv
// Self-checking bench: transaction-timeline model of the sequencer plus a ROM/MAC model
// that checks each finished C column against a plain matrix product.
module tb_a_rom_matmul_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] rom_addr;
    logic       mac_en;
    logic       mac_clr;
    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic [1:0] vec_idx;
    logic       out_valid;
    logic       busy;
    logic       done;

    a_rom_matmul_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .rom_addr (rom_addr),
        .mac_en   (mac_en),
        .mac_clr  (mac_clr),
        .row_idx  (row_idx),
        .col_idx  (col_idx),
        .vec_idx  (vec_idx),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A stored column-major: rom_a[c*3 + r] = A[r][c]
    logic [7:0] rom_a [9];
    initial begin
        rom_a[0] = 8'hE3; rom_a[1] = 8'hC0; rom_a[2] = 8'h76;
        rom_a[3] = 8'h5A; rom_a[4] = 8'h11; rom_a[5] = 8'hFF;
        rom_a[6] = 8'h08; rom_a[7] = 8'h9C; rom_a[8] = 8'h3D;
    end

    // ROM with one-cycle registered read and the MAC array it feeds
    logic [7:0] rom_q = 8'h00;
    int         acc [3];
    int         cur_b [3];
    bit         ident;

    always @(posedge clk) begin
        rom_q <= (rom_addr < 4'd9) ? rom_a[rom_addr] : 8'h00;
        if (mac_en) begin
            if (mac_clr) acc[row_idx] <= int'(rom_q) * cur_b[col_idx];
            else         acc[row_idx] <= acc[row_idx] + int'(rom_q) * cur_b[col_idx];
        end
    end

    // Timeline model: m_t counts cycles since the first address of a vector (-1 = none active)
    bit m_busy = 0;
    bit m_wait = 0;
    int m_t    = -1;
    int m_vec  = 0;
    int e_addr;
    bit e_en;
    int e_row;
    int e_col;
    int exp_c;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_wait = 0;
            m_t    = -1;
            m_vec  = 0;
        end
        e_en   = (m_t >= 1) && (m_t <= 9);
        e_addr = (m_t >= 0 && m_t <= 8) ? m_t : 15;
        e_row  = e_en ? (m_t - 1) % 3 : 0;
        e_col  = e_en ? (m_t - 1) / 3 : 0;
        check("rom_addr",  32'(rom_addr),  32'(e_addr));
        check("busy",      32'(busy),      32'(m_busy));
        check("b_ready",   32'(b_ready),   32'(m_wait));
        check("mac_en",    32'(mac_en),    32'(e_en));
        check("mac_clr",   32'(mac_clr),   32'(e_en && e_col == 0));
        check("vec_idx",   32'(vec_idx),   32'(m_vec));
        check("out_valid", 32'(out_valid), 32'(m_t == 10));
        check("done",      32'(done),      32'(m_t == 10 && m_vec == 2));
        if (e_en) begin
            check("row_idx", 32'(row_idx), 32'(e_row));
            check("col_idx", 32'(col_idx), 32'(e_col));
        end
        if (m_t == 10) begin
            for (int r = 0; r < 3; r++) begin
                exp_c = 0;
                for (int c = 0; c < 3; c++) exp_c += int'(rom_a[c*3 + r]) * cur_b[c];
                check("c_elem", 32'(acc[r]), 32'(exp_c));
            end
        end
        if (!rst) begin
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    m_wait = 1;
                    m_vec  = 0;
                end
            end else if (m_wait) begin
                if (b_valid) begin
                    m_wait = 0;
                    m_t    = 0;
                    for (int c = 0; c < 3; c++)
                        cur_b[c] = ident ? int'(c == m_vec) : int'($urandom_range(0, 255));
                end
            end else if (m_t == 10) begin
                m_t = -1;
                if (m_vec == 2) begin
                    m_busy = 0;
                    m_vec  = 0;
                end else begin
                    m_vec++;
                    m_wait = 1;
                end
            end else begin
                m_t++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = out_valid;
        end
        if (!seen) check("timeout_out_valid", 32'(0), 32'(1));
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = done;
        end
        if (!seen) check("timeout_done", 32'(0), 32'(1));
    endtask

    logic [1:0] exp_row [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    logic [1:0] exp_col [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

    initial begin
        bit seen;
        rst     = 1'b1;
        start   = 1'b0;
        b_valid = 1'b0;
        ident   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_addr", 32'(rom_addr), 32'hF);
            check("idle_busy", 32'(busy), 32'(0));
        end

        // Single product with b_valid tied high, B = identity
        b_valid = 1'b1;
        start   = 1'b1;
        for (int t = 1; t <= 37; t++) begin
            tick();
            if (t == 1) begin
                start = 1'b0;
                check("t1_b_ready", 32'(b_ready), 32'(1));
            end
            if (t >= 2 && t <= 10) check("seq_addr", 32'(rom_addr), 32'(t - 2));
            if (t >= 3 && t <= 11) begin
                check("seq_mac_en", 32'(mac_en), 32'(1));
                check("seq_row", 32'(row_idx), 32'(exp_row[t-3]));
                check("seq_col", 32'(col_idx), 32'(exp_col[t-3]));
                check("seq_clr", 32'(mac_clr), 32'(t <= 5));
            end
            if (t == 12) begin
                check("t12_out_valid", 32'(out_valid), 32'(1));
                check("t12_vec", 32'(vec_idx), 32'(0));
                check("gold_c0", 32'(acc[0]), 32'hE3);
                check("gold_c1", 32'(acc[1]), 32'hC0);
                check("gold_c2", 32'(acc[2]), 32'h76);
            end
            if (t == 36) begin
                check("t36_done", 32'(done), 32'(1));
                check("t36_out_valid", 32'(out_valid), 32'(1));
                start = 1'b1;
            end
            if (t == 37) begin
                check("start_at_done_ignored", 32'(busy), 32'(0));
                start = 1'b0;
            end
        end

        // Backpressure after the first EMIT, plus a start pulse mid-RUN
        ident = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_out_valid();
        b_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_b_ready", 32'(b_ready), 32'(1));
            check("bp_addr", 32'(rom_addr), 32'hF);
        end
        tick();
        b_valid = 1'b1;
        check("bp_still_waiting", 32'(b_ready), 32'(1));
        tick();
        check("bp_resume_addr", 32'(rom_addr), 32'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_out_valid();
        check("bp_vec_idx", 32'(vec_idx), 32'(1));
        wait_done();

        // Randomized b_valid and stray start pulses across several products
        for (int run = 0; run < 4; run++) begin
            tick();
            start   = 1'b1;
            b_valid = 1'($urandom_range(0, 1));
            seen    = 0;
            for (int i = 0; i < 400 && !seen; i++) begin
                tick();
                start   = ($urandom_range(0, 7) == 0);
                b_valid = 1'($urandom_range(0, 1));
                seen    = done;
            end
            if (!seen) check("timeout_random_run", 32'(0), 32'(1));
        end
        start = 1'b0;

        // Asynchronous reset mid-RUN at address 5, then a clean restart
        ident   = 1'b1;
        b_valid = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = (rom_addr == 4'd5);
        end
        if (!seen) check("timeout_addr5", 32'(0), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_addr",      32'(rom_addr),  32'hF);
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_b_ready",   32'(b_ready),   32'(0));
        check("rst_mac_en",    32'(mac_en),    32'(0));
        check("rst_mac_clr",   32'(mac_clr),   32'(0));
        check("rst_row",       32'(row_idx),   32'(0));
        check("rst_col",       32'(col_idx),   32'(0));
        check("rst_vec",       32'(vec_idx),   32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_done",      32'(done),      32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_b_ready", 32'(b_ready), 32'(1));
        tick();
        check("restart_addr0", 32'(rom_addr), 32'(0));
        check("restart_vec0", 32'(vec_idx), 32'(0));
        wait_done();

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/a_rom_matmul_seq.md
Name: a_rom_matmul_seq

Overview:
- Sequencer that drives the 3x3 A-coefficient ROM for a matrix product C = A*B, streaming one B column (vector) at a time.
- Generates ROM addresses in the ROM's column-major order (addr = col*N_ROW + row).
- Absorbs the ROM's one-cycle registered-read latency and emits aligned MAC enable/clear strobes, row/column indices and per-vector result strobes.
- Sits between the top-level control (start/done), the B-vector source (valid/ready) and the row-parallel MAC array.

Parameters:
- N_ROW, 3, rows of A; also the number of MAC accumulators.
- N_COL, 3, columns of A; also the elements per B vector.
- NUM_VEC, 3, B columns processed per start.
- ADDR_W, 4, ROM address width.
- IDLE_ADDR, 4'hF, address driven when not reading; the ROM returns 0 for it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a full product; ignored while busy=1.
- b_valid  in  1  B-vector source has the next column available.
- b_ready  out  1  sequencer accepts a B column; high only in WAIT_B.
- rom_addr  out  ADDR_W  ROM read address.
- mac_en  out  1  ROM output is a valid A element this cycle.
- mac_clr  out  1  with mac_en: load the product instead of accumulating (first column).
- row_idx  out  2  accumulator select, aligned with mac_en.
- col_idx  out  2  B element select, aligned with mac_en.
- vec_idx  out  2  index of the B column in progress.
- out_valid  out  1  one-cycle pulse: all N_ROW accumulators hold the finished C column vec_idx.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse coincident with the final out_valid.

Behaviour:
- Reset (asynchronous, immediate; also mid-operation): state=IDLE, rom_addr=IDLE_ADDR, all counters=0, and b_ready, mac_en, mac_clr, row_idx, col_idx, vec_idx, out_valid, busy, done all 0.
- FSM states: IDLE, WAIT_B, RUN, DRAIN, EMIT.
- IDLE: on start, go to WAIT_B with vec_idx=0.
- WAIT_B: b_ready=1 and rom_addr=IDLE_ADDR. On b_valid&b_ready, go to RUN with row=0, col=0. Otherwise wait indefinitely; there is no timeout.
- RUN: each cycle drive rom_addr = col*N_ROW + row.
  - row increments fastest; it wraps at N_ROW-1 and increments col.
  - After issuing address N_ROW*N_COL-1 (8 by default), go to DRAIN.
- Alignment pipeline: one register stage on (issue, row, col).
  - mac_en, row_idx and col_idx are the RUN-cycle values delayed by exactly 1 cycle, matching the ROM read latency.
  - mac_clr = mac_en & (col_idx==0).
- DRAIN: rom_addr=IDLE_ADDR. The final aligned mac_en (row 2, col 2) is active this cycle. Go to EMIT.
- EMIT: out_valid=1 for exactly one cycle.
  - If vec_idx==NUM_VEC-1: done=1, go to IDLE, vec_idx returns to 0.
  - Otherwise: vec_idx+1, go to WAIT_B.
- Per-vector latency from handshake to out_valid: 1+N_ROW*N_COL+1 cycles (11 by default). Minimum cycles per vector including the handshake cycle: 12.
- Outside RUN, rom_addr is always IDLE_ADDR, so any ROM output not qualified by mac_en is 0.
- mac_en is never active in WAIT_B, IDLE or EMIT.
- b_valid outside WAIT_B is ignored; no B column is consumed.
- start while busy is ignored and does not restart or extend the run.
- start in the same cycle as the done pulse is ignored (busy=1); start is accepted in the following IDLE cycle.
- Counter widths: row and col fit 2 bits; the address is computed at ADDR_W width with no truncation for default parameters.

Test Plan:
- Reset then idle: rst pulse, no start for 20 cycles -> rom_addr=4'hF; busy, b_ready, mac_en and out_valid stay 0.
- Single product, b_valid tied high, start at T0:
  - b_ready at T1.
  - rom_addr 0..8 at T2..T10.
  - mac_en T3..T11, with row_idx 0,1,2 repeating and col_idx 0,0,0,1,1,1,2,2,2.
  - mac_clr only at T3..T5.
  - out_valid at T12 with vec_idx=0; three vectors total, done coincident with the third out_valid at T36.
- Golden check: MAC model fed by the ROM output and B=identity -> C equals A in column-major order (first column 0xE3, 0xC0, 0x76).
- Backpressure: b_valid low for 5 cycles after the first EMIT -> b_ready held and rom_addr=4'hF throughout. The sequence resumes exactly one cycle after b_valid rises; vec_idx=1 on the next out_valid.
- Ignored inputs: start pulsed mid-RUN, and b_valid pulsed in RUN and DRAIN -> no change in address sequence, vec_idx or done timing.
- Async reset mid-RUN at rom_addr=5 -> on the same edge, outputs return to reset values and the state is IDLE. A new start runs the full product from vec_idx=0 and addr 0.
